// File: rtl/harmonic_scheduler.sv
// Per-sample sequencer for the harmonic scaling multiplier: restarts it on each
// sample tick, walks harmonics and hands index/multiple/mute downstream.
module harmonic_scheduler #(
  parameter int DIV_BIT  = 9,
  parameter int HARM_BIT = 8
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic                i_Sample_Tick,
  input  logic [HARM_BIT-1:0] i_Harm_Count,
  input  logic                i_Nyquist_Hit,
  input  logic [DIV_BIT-1:0]  i_Mult,
  input  logic                i_Mult_Ready,
  input  logic                i_Comb_Muted,
  input  logic                i_Harm_Ready,
  output logic                o_Restart,
  output logic                o_Start,
  output logic                o_Harm_Valid,
  output logic [HARM_BIT-1:0] o_Harm_Index,
  output logic [DIV_BIT-1:0]  o_Harm_Mult,
  output logic                o_Harm_Muted,
  output logic                o_Busy,
  output logic                o_Sample_Done,
  output logic                o_Overrun
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RESTART,
    S_SETTLE,
    S_CHECK,
    S_EMIT,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [HARM_BIT-1:0] last_index;

  // Only consulted in EMIT, where the index is already known to be below the count.
  assign last_index = i_Harm_Count - HARM_BIT'(1);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= S_IDLE;
      o_Restart     <= 1'b0;
      o_Start       <= 1'b0;
      o_Harm_Valid  <= 1'b0;
      o_Harm_Index  <= '0;
      o_Harm_Mult   <= '0;
      o_Harm_Muted  <= 1'b0;
      o_Busy        <= 1'b0;
      o_Sample_Done <= 1'b0;
      o_Overrun     <= 1'b0;
    end else begin
      o_Restart     <= 1'b0;
      o_Start       <= 1'b0;
      o_Sample_Done <= 1'b0;
      o_Overrun     <= i_Sample_Tick && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (i_Sample_Tick) begin
            state        <= S_RESTART;
            o_Harm_Index <= '0;
            o_Busy       <= 1'b1;
            o_Restart    <= 1'b1;
          end
        end

        S_RESTART: state <= S_SETTLE;

        S_SETTLE: state <= S_CHECK;

        S_CHECK: begin
          if ((o_Harm_Index >= i_Harm_Count) || i_Nyquist_Hit) begin
            state         <= S_DONE;
            o_Sample_Done <= 1'b1;
          end else begin
            state        <= S_EMIT;
            o_Harm_Mult  <= i_Mult;
            o_Harm_Muted <= i_Comb_Muted;
            o_Harm_Valid <= 1'b1;
          end
        end

        // A zero multiple means every further harmonic would also be zero.
        S_EMIT: begin
          if (i_Harm_Ready) begin
            o_Harm_Valid <= 1'b0;
            if ((o_Harm_Mult == '0) || (o_Harm_Index == last_index)) begin
              state         <= S_DONE;
              o_Sample_Done <= 1'b1;
            end else begin
              state        <= S_ISSUE;
              o_Start      <= 1'b1;
              o_Harm_Index <= o_Harm_Index + HARM_BIT'(1);
            end
          end
        end

        S_ISSUE: state <= S_GUARD;

        // Multiplier ready is still stale high here, so it is not looked at.
        S_GUARD: state <= S_WAIT;

        S_WAIT: begin
          if (i_Mult_Ready) state <= S_CHECK;
        end

        S_DONE: begin
          o_Busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
